// File: rtl/car_lane_controller_if.sv
// Control and position bundle between the game-state controller, the frog
// controller / renderer (master side) and car_lane_controller (slave side).
interface car_lane_controller_if;
    logic        reset_cars;
    logic        freeze;
    logic [3:0]  level;
    logic [79:0] car_x;
    logic [63:0] car_y;
    logic [7:0]  lane_step;

    modport master (
        output reset_cars, freeze, level,
        input  car_x, car_y, lane_step
    );

    modport slave (
        input  reset_cars, freeze, level,
        output car_x, car_y, lane_step
    );
endinterface

// File: rtl/car_lane_controller.sv
// Eight traffic lanes of two cars each, stepped by a shared tick prescaler and per-lane periods.
// Optional `CAR_LFSR_GAP_EN parks wrapping cars off-grid (x=31) for a pseudo-random number of steps.
module car_lane_controller #(
    parameter int GRID_COLS   = 20,
    parameter int TICK_DIV    = 2500000,
    parameter int BASE_PERIOD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    car_lane_controller_if.slave  cars
);

    localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [4:0]     X_MAX   = 5'(GRID_COLS - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          restart;
    logic [7:0]    lane_cnt  [8];
    logic [7:0]    lane_sub  [8];
    logic [7:0]    period    [8];
    logic [7:0]    step_now;
    logic [7:0]    lane_step_q;
    logic [4:0]    x_q       [16];

    assign restart = reset | cars.reset_cars;
    assign tick    = !cars.freeze && (pre_cnt == PRE_MAX);

    function automatic logic [4:0] init_x(input int k);
        return 5'((3 * (k / 2) + 10 * (k % 2)) % GRID_COLS);
    endfunction

    function automatic logic [4:0] move_x(input logic [4:0] x, input logic right);
        if (right)
            return (x == X_MAX) ? 5'd0 : x + 5'd1;
        else
            return (x == 5'd0) ? X_MAX : x - 5'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (restart)
            pre_cnt <= '0;
        else if (!cars.freeze)
            pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PW'(1);
    end

    // Saturating period so high levels bottom out at one tick per step.
    always_comb begin
        for (int l = 0; l < 8; l++) begin
            lane_sub[l] = 8'(l % 4) + 8'(cars.level);
            if (lane_sub[l] >= 8'(BASE_PERIOD))
                period[l] = 8'd1;
            else
                period[l] = 8'(BASE_PERIOD) - lane_sub[l];
            step_now[l] = tick && (lane_cnt[l] >= period[l] - 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            lane_step_q <= '0;
            for (int l = 0; l < 8; l++)
                lane_cnt[l] <= '0;
        end else begin
            lane_step_q <= step_now;
            if (tick) begin
                for (int l = 0; l < 8; l++)
                    lane_cnt[l] <= step_now[l] ? 8'd0 : lane_cnt[l] + 8'd1;
            end
        end
    end

`ifdef CAR_LFSR_GAP_EN
    localparam logic [4:0] PARK_X = 5'd31;

    logic [15:0] lfsr;
    logic [1:0]  park [16];

    always_ff @(posedge clk) begin
        if (restart)
            lfsr <= 16'hACE1;
        else if (tick)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    // A parked car re-enters at the edge it would have wrapped to.
    always_ff @(posedge clk) begin
        if (restart) begin
            for (int k = 0; k < 16; k++) begin
                x_q[k] <= init_x(k);
`ifdef CAR_LFSR_GAP_EN
                park[k] <= 2'd0;
`endif
            end
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (step_now[k / 2]) begin
`ifdef CAR_LFSR_GAP_EN
                    if (x_q[k] == PARK_X) begin
                        if (park[k] <= 2'd1) begin
                            x_q[k]  <= ((k / 2) % 2 == 0) ? 5'd0 : X_MAX;
                            park[k] <= 2'd0;
                        end else begin
                            park[k] <= park[k] - 2'd1;
                        end
                    end else if ((lfsr[1:0] != 2'd0) &&
                                 ((((k / 2) % 2 == 0) && (x_q[k] == X_MAX)) ||
                                  (((k / 2) % 2 == 1) && (x_q[k] == 5'd0)))) begin
                        x_q[k]  <= PARK_X;
                        park[k] <= lfsr[1:0];
                    end else begin
                        x_q[k] <= move_x(x_q[k], (k / 2) % 2 == 0);
                    end
`else
                    x_q[k] <= move_x(x_q[k], (k / 2) % 2 == 0);
`endif
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_pack
            assign cars.car_x[5*g +: 5] = x_q[g];
            assign cars.car_y[4*g +: 4] = 4'(12 - g / 2);
        end
    endgenerate

    assign cars.lane_step = lane_step_q & {8{~cars.freeze}};

endmodule

// File: tb/tb_car_lane_controller.sv
// Bench for car_lane_controller: directed scenarios plus random level/freeze/restart traffic,
// all checked every cycle against a step-counting model of the lanes.
module tb_car_lane_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    car_lane_controller_if bus();

    car_lane_controller #(
        .GRID_COLS  (20),
        .TICK_DIV   (4),
        .BASE_PERIOD(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cars  (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    // Model: cars are described by how many steps their lane has taken since restart.
    int mPhase;
    int mSince [8];
    int mSteps [8];
    bit mPulse [8];
    bit mTick;

    function automatic int lanePeriod(input int l, input int lvl);
        int p;
        p = 8 - (l % 4) - lvl;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic int expX(input int k);
        int l, x0;
        l  = k / 2;
        x0 = (3 * l + 10 * (k % 2)) % 20;
        if (l % 2 == 0)
            return (x0 + mSteps[l]) % 20;
        else
            return (x0 - (mSteps[l] % 20) + 20) % 20;
    endfunction

    function automatic logic [4:0] carX(input int k);
        return bus.car_x[5*k +: 5];
    endfunction

    always @(posedge clk) begin
        if (reset || bus.reset_cars) begin
            mPhase = 0;
            for (int l = 0; l < 8; l++) begin
                mSince[l] = 0;
                mSteps[l] = 0;
                mPulse[l] = 0;
            end
        end else if (bus.freeze) begin
            for (int l = 0; l < 8; l++)
                mPulse[l] = 0;
        end else begin
            mTick  = (mPhase == 3);
            mPhase = (mPhase + 1) % 4;
            for (int l = 0; l < 8; l++) begin
                mPulse[l] = 0;
                if (mTick) begin
                    mSince[l]++;
                    if (mSince[l] >= lanePeriod(l, int'(bus.level))) begin
                        mSince[l] = 0;
                        mSteps[l]++;
                        mPulse[l] = 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [79:0] ex;
        logic [63:0] ey;
        logic [7:0]  es;
        if (checkEn) begin
            for (int k = 0; k < 16; k++) begin
                ex[5*k +: 5] = 5'(expX(k));
                ey[4*k +: 4] = 4'(12 - k / 2);
            end
            for (int l = 0; l < 8; l++)
                es[l] = mPulse[l] & ~bus.freeze;
            checkOutput("model_car_x", bus.car_x, ex);
            checkOutput("model_car_y", 80'(bus.car_y), 80'(ey));
            checkOutput("model_lane_step", 80'(bus.lane_step), 80'(es));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit rst, input bit rc, input bit frz, input int lvl);
        reset          = rst;
        bus.reset_cars = rc;
        bus.freeze     = frz;
        bus.level      = 4'(lvl);
    endtask

    task automatic checkCar(input string name, input int k, input int exp);
        checkOutput(name, 80'(carX(k)), 80'(exp));
    endtask

    task automatic restartCars(input int lvl);
        applyStimulus(0, 1, 0, lvl);
        cycles(1);
        applyStimulus(0, 0, 0, lvl);
    endtask

    initial begin
        bit frz;
        int lvl;
        applyStimulus(1, 0, 0, 0);
        cycles(2);
        checkEn = 1;

        checkCar("reset_car0_x", 0, 0);
        checkOutput("reset_car0_y", 80'(bus.car_y[3:0]), 80'd12);
        checkCar("reset_car1_x", 1, 10);
        checkOutput("reset_car1_y", 80'(bus.car_y[7:4]), 80'd12);
        checkCar("reset_car6_x", 6, 9);
        checkOutput("reset_car6_y", 80'(bus.car_y[27:24]), 80'd9);
        checkCar("reset_car14_x", 14, 1);
        checkOutput("reset_car14_y", 80'(bus.car_y[59:56]), 80'd5);
        checkCar("reset_car15_x", 15, 11);
        checkOutput("reset_car15_y", 80'(bus.car_y[63:60]), 80'd5);
        checkOutput("reset_lane_step", 80'(bus.lane_step), 80'd0);

        checkOutput("model_period_l0", 80'(lanePeriod(0, 0)), 80'd8);
        checkOutput("model_period_l3", 80'(lanePeriod(3, 0)), 80'd5);
        checkOutput("model_period_l7_lvl15", 80'(lanePeriod(7, 15)), 80'd1);
        checkOutput("model_reset_car15", 80'(expX(15)), 80'd11);

        applyStimulus(0, 0, 0, 0);
        cycles(20);
        checkCar("t20_car6_x", 6, 8);
        checkCar("t20_car14_x", 14, 0);
        checkCar("t20_car0_x", 0, 0);
        checkOutput("t20_lane_step", 80'(bus.lane_step), 80'h88);
        cycles(8);
        checkCar("t28_car3_x", 3, 12);
        checkOutput("t28_lane_step", 80'(bus.lane_step), 80'h22);
        cycles(3);
        checkCar("t31_car0_x", 0, 0);
        checkOutput("t31_lane_step", 80'(bus.lane_step), 80'h00);
        cycles(1);
        checkCar("t32_car0_x", 0, 1);
        checkOutput("t32_lane_step", 80'(bus.lane_step), 80'h11);
        cycles(8);
        checkCar("t40_car14_wrap", 14, 19);
        checkCar("t40_car15_x", 15, 9);
        checkOutput("t40_lane_step", 80'(bus.lane_step), 80'h88);

        restartCars(7);
        cycles(4);
        checkOutput("lvl7_all_step", 80'(bus.lane_step), 80'hFF);
        checkCar("lvl7_car0_x", 0, 1);
        checkCar("lvl7_car1_x", 1, 11);
        cycles(1);
        checkOutput("lvl7_no_step", 80'(bus.lane_step), 80'h00);
        cycles(3);
        checkOutput("lvl7_all_step2", 80'(bus.lane_step), 80'hFF);
        checkCar("lvl7_car0_x2", 0, 2);
        applyStimulus(0, 0, 0, 15);
        cycles(4);
        checkOutput("lvl15_all_step", 80'(bus.lane_step), 80'hFF);
        checkCar("lvl15_car0_x", 0, 3);

        restartCars(0);
        cycles(45);
        applyStimulus(0, 0, 1, 0);
        cycles(100);
        checkCar("freeze_car0_x", 0, 1);
        checkCar("freeze_car6_x", 6, 7);
        checkOutput("freeze_lane_step", 80'(bus.lane_step), 80'h00);
        applyStimulus(0, 0, 0, 0);
        cycles(18);
        checkCar("thaw18_car0_x", 0, 1);
        cycles(1);
        checkCar("thaw19_car0_x", 0, 2);
        checkOutput("thaw19_step0", 80'(bus.lane_step[0]), 80'd1);

        applyStimulus(0, 0, 1, 0);
        cycles(3);
        applyStimulus(0, 1, 1, 0);
        cycles(1);
        checkCar("rcfrz_car0_x", 0, 0);
        checkCar("rcfrz_car6_x", 6, 9);
        checkCar("rcfrz_car14_x", 14, 1);
        checkOutput("rcfrz_lane_step", 80'(bus.lane_step), 80'h00);
        applyStimulus(0, 0, 0, 0);
        cycles(31);
        checkCar("rcfrz31_car0_x", 0, 0);
        cycles(1);
        checkCar("rcfrz32_car0_x", 0, 1);
        checkOutput("rcfrz32_step0", 80'(bus.lane_step[0]), 80'd1);

        cycles(31);
        applyStimulus(0, 1, 0, 0);
        cycles(1);
        checkCar("rctick_car0_x", 0, 0);
        checkCar("rctick_car6_x", 6, 9);
        checkOutput("rctick_lane_step", 80'(bus.lane_step), 80'h00);
        applyStimulus(0, 0, 0, 0);
        cycles(32);
        checkCar("rctick32_car0_x", 0, 1);

        frz = 0;
        lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                frz = ~frz;
            if ($urandom_range(0, 49) == 0)
                lvl = $urandom_range(0, 15);
            applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0, frz, lvl);
            cycles(1);
        end

        applyStimulus(0, 0, 0, 0);
        cycles(2);
        checkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
